lcd_req_arbiter: RTL and testbench
==================================

Name: lcd_req_arbiter

Overview:
- Shares the single LCD character controller command port (lcd_enable / 10-bit lcd_bus / busy) between N independent requesters, such as a status-line writer, a cursor manager and a debug console.
- Round-robin arbitration; one command in flight at a time.
- Enforces a post-command hold-off, because the LCD controller's busy flag only pulses for one cycle on acceptance and is low while its enable strobe is still running.
- Sits between the requester logic and the LCD controller in the display subsystem.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 10, LCD command word width: {rs, rw, data[7:0]}.
- HOLD_CYCLES, 52, idle cycles after acceptance before the next issue (≥ LCD strobe window of 50 + 2 margin).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-requester request level.
- req_data_i  in  N_REQ*WORD_W  per-requester command word; slice k = bits [k*WORD_W +: WORD_W].
- gnt_o  out  N_REQ  one-hot, one-cycle pulse: the requester's word was accepted by the LCD.
- lcd_busy_i  in  1  busy from the LCD controller.
- lcd_enable_o  out  1  command strobe to the LCD controller.
- lcd_bus_o  out  WORD_W  command word to the LCD controller.
- arb_busy_o  out  1  high in every state except IDLE.
- owner_o  out  $clog2(N_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gnt_o=0; lcd_enable_o=0; lcd_bus_o=0; arb_busy_o=0; owner_o=0.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - Hold counter = 0.
- Reset asserted mid-command drops lcd_enable_o immediately. The requester receives no gnt and must retry.
- State IDLE:
  - If any req_i is high and lcd_busy_i==0, pick the first requester at or after pointer+1 (wrapping modulo N_REQ).
  - Latch its word into lcd_bus_o, set owner_o, and go to ISSUE.
  - If lcd_busy_i==1 (LCD still in power-up/init), stay in IDLE.
- State ISSUE:
  - lcd_enable_o=1; lcd_bus_o holds the latched word. Later changes on req_data_i or req_i are ignored.
  - On the first clock where lcd_busy_i==1: gnt_o[owner]=1 for exactly that cycle, lcd_enable_o=0, pointer=owner, counter=HOLD_CYCLES-1, go to HOLD.
- State HOLD:
  - lcd_enable_o=0; counter decrements each cycle.
  - When counter==0, go to IDLE. lcd_bus_o keeps its last value.
- Latency: with req_i high in IDLE at edge t, lcd_enable_o is high after edge t. Given a 1-cycle registered LCD busy, gnt_o pulses after edge t+2.
- Minimum spacing between consecutive lcd_enable_o rises: HOLD_CYCLES+3 cycles.
- Handshake rules:
  - A requester holds req_i high until it sees gnt_o.
  - req_i deasserted while owning in ISSUE is a protocol violation. The command still completes and gnt_o still pulses.
- Simultaneous events:
  - gnt_o and a new req_i from the same requester in the same cycle: the new request is considered only from the next IDLE.
  - A requester re-requesting immediately is served after every other pending requester (fairness bound: N_REQ-1 foreign commands).
- Width rule: pointer arithmetic wraps modulo N_REQ. N_REQ need not be a power of 2.

Optional Feature:
- LCD_ARB_PRIO0_EN: when defined, requester 0 has strict priority in IDLE; remaining requesters are round-robin among themselves, and granting requester 0 does not move the pointer.
- Without the macro: pure round-robin across all N_REQ requesters.

Decomposition:
- Shared package lcd_pkg:
  - LCD_WORD_W=10, LCD_RS_BIT=9, LCD_RW_BIT=8.
  - State enum {IDLE, ISSUE, HOLD}.
  - LCD_STROBE_CYCLES=50 (used to derive the HOLD_CYCLES default).
- One sub-module, lcd_rr_pick: combinational round-robin selector, inputs req and pointer, outputs valid and index. It is reused by the priority variant over the masked request vector.

Test Plan:
- Reset with req_i=4'b0001, lcd_busy_i held 1 for 500 cycles → lcd_enable_o stays 0. busy drops → lcd_enable_o rises next cycle with lcd_bus_o = req_data_i slice 0.
- req_i=4'b1111 with distinct words 0x101, 0x202, 0x303, 0x0C4, bench LCD model pulsing busy for 1 cycle → grants in order 0,1,2,3, each gnt_o a 1-cycle pulse. Enable rises are spaced ≥55 cycles apart.
- Requester 2 re-asserts req the cycle after its gnt while 0 and 3 are pending → order 3, 0, 2.
- Change req_data_i slice 1 from 0x155 to 0x0AA during ISSUE → lcd_bus_o stays 0x155 until the next IDLE selection.
- Assert rst_n=0 in the middle of ISSUE → lcd_enable_o=0 and gnt_o=0 asynchronously. After release, requester 0 wins first.
- With LCD_ARB_PRIO0_EN and req_i=4'b0111 held → requester 0 is granted every time. Drop req 0 → grants 1, 2, 1, 2.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD command-port definitions: word layout, strobe timing and arbiter states.
package lcd_pkg;

  localparam int LCD_WORD_W        = 10;
  localparam int LCD_RS_BIT        = 9;
  localparam int LCD_RW_BIT        = 8;
  localparam int LCD_STROBE_CYCLES = 50;
  localparam int LCD_HOLD_MARGIN   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } lcd_state_e;

  function automatic logic [LCD_WORD_W-1:0] lcd_word(input logic rs, input logic rw,
                                                     input logic [7:0] data);
    logic [LCD_WORD_W-1:0] w;
    w             = '0;
    w[LCD_RS_BIT] = rs;
    w[LCD_RW_BIT] = rw;
    w[7:0]        = data;
    return w;
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i+1, wrapping modulo N_REQ.
module lcd_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr_i < N_REQ, so a single subtraction is enough to wrap.
      cand = int'(ptr_i) + 1 + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/lcd_req_arbiter.sv
// Round-robin arbiter sharing one LCD controller command port between N_REQ requesters.
// Optional build macro LCD_ARB_PRIO0_EN gives requester 0 strict priority.
module lcd_req_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WORD_W      = LCD_WORD_W,
  parameter int HOLD_CYCLES = LCD_STROBE_CYCLES + LCD_HOLD_MARGIN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*WORD_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          gnt_o,
  input  logic                      lcd_busy_i,
  output logic                      lcd_enable_o,
  output logic [WORD_W-1:0]         lcd_bus_o,
  output logic                      arb_busy_o,
  output logic [$clog2(N_REQ)-1:0]  owner_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  // Handshake: a requester raises req_i and keeps it high until it sees its one-cycle
  // gnt_o pulse; the arbiter asserts lcd_enable_o until lcd_busy_i reports acceptance.
  lcd_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] bus_q, bus_d;
  logic              en_q, en_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic [N_REQ-1:0]  rr_req;
  logic              rr_valid;
  logic [IDX_W-1:0]  rr_idx;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;

`ifdef LCD_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the rest rotate among themselves.
  assign rr_req    = {req_i[N_REQ-1:1], 1'b0};
  assign sel_valid = req_i[0] | rr_valid;
  assign sel_idx   = req_i[0] ? '0 : rr_idx;
`else
  assign rr_req    = req_i;
  assign sel_valid = rr_valid;
  assign sel_idx   = rr_idx;
`endif

  lcd_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (rr_req),
    .ptr_i   (ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (sel_valid && !lcd_busy_i) begin
          owner_d = sel_idx;
          bus_d   = req_data_i[sel_idx*WORD_W +: WORD_W];
          en_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        en_d = 1'b1;
        if (lcd_busy_i) begin
          gnt_d   = N_REQ'(1) << owner_q;
          en_d    = 1'b0;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = HOLD;
`ifdef LCD_ARB_PRIO0_EN
          if (owner_q != '0) ptr_d = owner_q;
`else
          ptr_d = owner_q;
`endif
        end
      end
      HOLD: begin
        en_d = 1'b0;
        // The controller's busy is already low while its strobe window runs; wait it out.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign lcd_enable_o = en_q;
  assign lcd_bus_o    = bus_q;
  assign owner_o      = owner_q;
  assign arb_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Self-checking bench for lcd_req_arbiter with a registered one-cycle-busy LCD model.
module tb_lcd_req_arbiter;
  import lcd_pkg::*;

  localparam int N       = 4;
  localparam int W       = 10;
  localparam int IW      = 2;
  localparam int EW      = IW + W;
  localparam int HOLD    = 52;
  localparam int SPACING = HOLD + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   req_data_i;
  logic [N-1:0]     gnt_o;
  logic             lcd_busy_i;
  logic             lcd_enable_o;
  logic [W-1:0]     lcd_bus_o;
  logic             arb_busy_o;
  logic [IW-1:0]    owner_o;

  logic             init_busy;
  logic             model_busy_q;

  logic [EW-1:0]    exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;

  // ---------------- clock / reset / LCD model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_busy_q <= 1'b0;
    else        model_busy_q <= lcd_enable_o & ~model_busy_q;
  end
  assign lcd_busy_i = init_busy | model_busy_q;

  lcd_req_arbiter #(
    .N_REQ       (N),
    .WORD_W      (W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .req_data_i   (req_data_i),
    .gnt_o        (gnt_o),
    .lcd_busy_i   (lcd_busy_i),
    .lcd_enable_o (lcd_enable_o),
    .lcd_bus_o    (lcd_bus_o),
    .arb_busy_o   (arb_busy_o),
    .owner_o      (owner_o)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_word(input int k, input logic [W-1:0] w);
    req_data_i[k*W +: W] = w;
  endtask

  task automatic push(input int k, input logic [W-1:0] w);
    exp_q.push_back({IW'(k), w});
  endtask

  task automatic wait_grants(input int n, input logic [N-1:0] keep);
    int got;
    got = 0;
    for (int c = 0; c < n * (SPACING + 10) + 20 && got < n; c++) begin
      @(negedge clk);
      if (gnt_o != '0) begin
        got++;
        req_i = req_i & ~(gnt_o & ~keep);
      end
    end
    check("grant_count", got, n);
  endtask

  task automatic wait_rise();
    int seen;
    seen = 0;
    for (int c = 0; c < SPACING + 20 && seen == 0; c++) begin
      @(negedge clk);
      if (lcd_enable_o) seen = 1;
    end
    check("rise_timeout", seen, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          en_prev   = 1'b0;
  logic [N-1:0]  gnt_prev  = '0;
  int            last_rise = -1;
  logic [EW-1:0] e;
  logic [W-1:0]  e_word;
  logic [IW-1:0] e_idx;

  always @(negedge clk) begin
    if (rst_n) begin
      if (lcd_enable_o && !en_prev) begin
        if (last_rise >= 0) check("rise_spacing_ok", 32'(cyc - last_rise >= SPACING), 1);
        last_rise = cyc;
        if (exp_q.size() > 0) begin
          e      = exp_q[0];
          e_word = e[W-1:0];
          check("bus_at_issue", lcd_bus_o, e_word);
        end
      end
      if (gnt_prev != '0) check("gnt_pulse_width", gnt_o, 0);
      if (gnt_o != '0) begin
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", gnt_o, 0);
        end else begin
          e      = exp_q.pop_front();
          e_word = e[W-1:0];
          e_idx  = e[EW-1:W];
          check("gnt_onehot", gnt_o, 32'(1) << e_idx);
          check("gnt_word", lcd_bus_o, e_word);
          check("gnt_owner", owner_o, e_idx);
        end
      end
    end else begin
      last_rise = -1;
    end
    en_prev  = lcd_enable_o;
    gnt_prev = gnt_o;
  end

  // ---------------- stimulus ----------------
  int hi_cnt;

  initial begin
    rst_n      = 1'b0;
    req_i      = '0;
    req_data_i = '0;
    init_busy  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_enable", lcd_enable_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_bus", lcd_bus_o, 0);
    check("rst_arb_busy", arb_busy_o, 0);
    check("rst_owner", owner_o, 0);

    // LCD still initialising: nothing may issue while busy is held.
    req_i = 4'b0001;
    set_word(0, 10'h1A5);
    rst_n = 1'b1;
    hi_cnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (lcd_enable_o) hi_cnt++;
    end
    check("init_busy_enable_cycles", hi_cnt, 0);
    check("init_busy_idle", arb_busy_o, 0);
    push(0, 10'h1A5);
    init_busy = 1'b0;
    @(negedge clk);
    check("enable_after_busy", lcd_enable_o, 1);
    check("bus_after_busy", lcd_bus_o, 10'h1A5);
    check("arb_busy_issue", arb_busy_o, 1);
    wait_grants(1, '0);

`ifdef LCD_ARB_PRIO0_EN
    set_word(0, 10'h101);
    set_word(1, 10'h202);
    set_word(2, 10'h303);
    req_i = 4'b0111;
    for (int i = 0; i < 3; i++) push(0, 10'h101);
    wait_grants(3, 4'b0111);
    req_i[0] = 1'b0;
    push(1, 10'h202); push(2, 10'h303); push(1, 10'h202); push(2, 10'h303);
    wait_grants(4, 4'b0110);
    req_i = '0;
`else
    // Abort a command mid-ISSUE: enable and grant must drop at once.
    set_word(1, 10'h0F0);
    req_i = 4'b0010;
    push(1, 10'h0F0);
    wait_rise();
    rst_n = 1'b0;
    #1;
    check("abort_enable", lcd_enable_o, 0);
    check("abort_gnt", gnt_o, 0);
    check("abort_arb_busy", arb_busy_o, 0);
    check("abort_owner", owner_o, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);

    // After release requester 0 wins first, then strict rotation.
    set_word(0, 10'h101);
    set_word(1, 10'h202);
    set_word(2, 10'h303);
    set_word(3, 10'h0C4);
    req_i = 4'b1111;
    push(0, 10'h101); push(1, 10'h202); push(2, 10'h303); push(3, 10'h0C4);
    rst_n = 1'b1;
    wait_grants(4, '0);

    // Word is latched at selection; data change and early req drop are ignored.
    set_word(1, 10'h155);
    req_i = 4'b0010;
    push(1, 10'h155);
    wait_rise();
    set_word(1, 10'h0AA);
    req_i[1] = 1'b0;
    wait_grants(1, '0);
    repeat (3) begin
      @(negedge clk);
      check("bus_hold_after_gnt", lcd_bus_o, 10'h155);
    end

    // Immediate re-request of 2 waits behind pending 3 and 0.
    set_word(0, 10'h011);
    set_word(2, 10'h222);
    set_word(3, 10'h333);
    req_i = 4'b1101;
    push(2, 10'h222); push(3, 10'h333); push(0, 10'h011);
    wait_grants(1, '0);
    @(negedge clk);
    set_word(2, 10'h2EE);
    req_i[2] = 1'b1;
    push(2, 10'h2EE);
    wait_grants(3, '0);
`endif

    repeat (SPACING) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("final_idle", arb_busy_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
